accumulator_datapath: RTL
=========================

// Module: accumulator_datapath
// PURPOSE
//  Accumulator-CPU datapath; the responder to the controller FSM's control strobes.
//  Holds IR, PC, Acc, Reg, ALU and Z/C flags; returns Opcode/Z/C to the controller.
//  Controller drives controls on negedge CLK; this block samples them and updates state on posedge CLK.
//  Drives PCAddr to the combinational program memory and captures InstrData into IR.
// PARAMETERS
//  DATA_W  8  Acc/Reg/ALU width; immediate field width.
//  ADDR_W  8  PC width; branch targets are truncated or zero-extended to ADDR_W.
// PORTS
//  CLK        in   1           single clock; all state updates on posedge.
//  CLB        in   1           reset; synchronous, active-low.
//  SelALU     in   4           ALU op: 0001 add, 0010 sub, 0011 nor, 1011 shl, 1100 shr.
//  SelAcc     in   2           Acc source: 1x ALU, 01 Reg, 00 immediate.
//  LoadAcc    in   1           load Acc from the SelAcc source.
//  LoadReg    in   1           Reg <= Acc.
//  LoadPC     in   1           PC <= branch target.
//  SelPC      in   1           target: 0 Reg, 1 immediate.
//  IncPC      in   1           PC <= PC+1.
//  LoadIR     in   1           IR <= InstrData.
//  InstrData  in   4+DATA_W    {opcode[3:0], imm[DATA_W-1:0]} at PCAddr.
//  PCAddr     out  ADDR_W      current PC.
//  Opcode     out  4           IR[3+DATA_W:DATA_W].
//  Z          out  1           zero flag.
//  C          out  1           carry flag.
//  AccOut     out  DATA_W      Acc value.
//  Halted     out  1           1 when Opcode==1111 and LoadIR==0 (combinational).
// BEHAVIOUR
//  - Reset (CLB==0 at posedge): PC, IR, Acc, Reg, Z, C <= 0; overrides all controls.
//    Reset mid-instruction discards that instruction's effects; the first post-reset IR is NOP.
//  - All registers use nonblocking updates. imm, Reg and Acc are the pre-edge values;
//    an instruction's own immediate is used on the same edge that IR is replaced.
//  - IR: loads InstrData when LoadIR==1; otherwise holds. Halt freezes IR and PC.
//  - PC priority: LoadPC > IncPC > hold. PC+1 wraps from 2^ADDR_W-1 to 0.
//  - ALU operates on {Acc, Reg} with a DATA_W+1-bit result:
//      add: Acc+Reg, C = carry out.
//      sub: Acc+~Reg+1, C = 1 iff Acc>=Reg (unsigned, no borrow).
//      nor: ~(Acc|Reg), C = 0.
//      shl: Acc<<1, C = Acc[MSB].
//      shr: Acc>>1 (logical), C = Acc[0].
//      Any other SelALU: result = Acc, C = 0.
//  - Z <= (new Acc == 0) on every LoadAcc, whatever the source.
//    C updates only on LoadAcc with SelAcc[1]==1; otherwise holds.
//  - LoadReg: Reg <= pre-edge Acc. LoadAcc and LoadReg together: both apply with pre-edge values (swap-safe).
//  - Latency: one posedge from a control strobe to its register update. Z/C are visible to the
//    controller at the following negedge.
// CONFIGURATION
//  DATAPATH_OVF_FLAG_EN: when defined, adds output port V (1 bit) and a V register, reset 0.
//    On ALU add/sub loads, V = signed overflow of the operation; on other ALU ops V = 0;
//    otherwise V holds.
//  When undefined: port V and its register do not exist; all other behaviour is unchanged.
// TESTING
//  1. Reset: CLB=0 for one posedge with LoadAcc=1, IncPC=1 -> PCAddr=0, Opcode=0, AccOut=0, Z=0, C=0.
//  2. Load immediate: IR imm=0x05, SelAcc=00, LoadAcc=1 -> AccOut=0x05, Z=0, C unchanged.
//     Then LoadReg=1 -> Reg=0x05.
//  3. Add wrap: Acc=0xFF, Reg=0x01, SelALU=0001, SelAcc=10, LoadAcc=1 -> AccOut=0x00, Z=1, C=1
//     (V=0 when DATAPATH_OVF_FLAG_EN is defined).
//  4. Sub/shift: Acc=0x03, Reg=0x05, sub -> AccOut=0xFE, C=0.
//     Then Acc=0x81, shl -> AccOut=0x02, C=1.
//     Then shr of 0x02 -> AccOut=0x01, C=0.
//  5. PC: imm=0x0A, LoadPC=1, SelPC=1, IncPC=1 -> PCAddr=0x0A (load wins).
//     PC=0xFF with IncPC=1 -> PCAddr=0x00.
//     SelPC=0 with Reg=0x33 -> PCAddr=0x33.
//  6. Halt: IR opcode=1111, LoadIR=0, IncPC=0 for 5 cycles -> PCAddr and IR constant, Halted=1.
//     A reset pulse then clears to PCAddr=0, Halted=0.

Source files
------------

// File: rtl/accumulator_datapath_if.sv
// Control/status bundle between the accumulator controller, program memory and datapath.
// DATAPATH_OVF_FLAG_EN adds the signed-overflow flag V.
interface accumulator_datapath_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic [3:0]          SelALU;
    logic [1:0]          SelAcc;
    logic                LoadAcc;
    logic                LoadReg;
    logic                LoadPC;
    logic                SelPC;
    logic                IncPC;
    logic                LoadIR;
    logic [3+DATA_W:0]   InstrData;
    logic [ADDR_W-1:0]   PCAddr;
    logic [3:0]          Opcode;
    logic                Z;
    logic                C;
    logic [DATA_W-1:0]   AccOut;
    logic                Halted;
`ifdef DATAPATH_OVF_FLAG_EN
    logic                V;
`endif

    modport master (
`ifdef DATAPATH_OVF_FLAG_EN
        input  V,
`endif
        output SelALU, SelAcc, LoadAcc, LoadReg, LoadPC, SelPC, IncPC, LoadIR, InstrData,
        input  PCAddr, Opcode, Z, C, AccOut, Halted
    );

    modport slave (
`ifdef DATAPATH_OVF_FLAG_EN
        output V,
`endif
        input  SelALU, SelAcc, LoadAcc, LoadReg, LoadPC, SelPC, IncPC, LoadIR, InstrData,
        output PCAddr, Opcode, Z, C, AccOut, Halted
    );
endinterface

// File: rtl/accumulator_datapath.sv
// Accumulator-CPU datapath: IR, PC, Acc, Reg, ALU and Z/C flags driven by controller strobes.
// DATAPATH_OVF_FLAG_EN adds a registered signed-overflow flag V for add/sub.
module accumulator_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input logic                   CLK,
    input logic                   CLB,
    accumulator_datapath_if.slave dp
);
    localparam int unsigned Msb  = DATA_W - 1;
    localparam int unsigned ResW = DATA_W + 1;

    logic [3+DATA_W:0] ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q, reg_q;
    logic              z_q, c_q;

    logic [DATA_W-1:0] imm;
    logic [ResW-1:0]   alu_res;
    logic [DATA_W-1:0] acc_d;
    logic [ADDR_W-1:0] pc_target;
    logic              halted;

    assign imm    = ir_q[DATA_W-1:0];
    assign halted = (ir_q[3+DATA_W:DATA_W] == 4'hF) && !dp.LoadIR;

    // Result MSB doubles as the carry for every op.
    always_comb begin
        alu_res = {1'b0, acc_q};
        unique case (dp.SelALU)
            4'b0001: alu_res = {1'b0, acc_q} + {1'b0, reg_q};
            4'b0010: alu_res = {1'b0, acc_q} + {1'b0, ~reg_q} + ResW'(1);
            4'b0011: alu_res = {1'b0, ~(acc_q | reg_q)};
            4'b1011: alu_res = {acc_q, 1'b0};
            4'b1100: alu_res = {acc_q[0], 1'b0, acc_q[Msb:1]};
            default: alu_res = {1'b0, acc_q};
        endcase
    end

    always_comb begin
        acc_d = imm;
        if (dp.SelAcc[1]) begin
            acc_d = alu_res[DATA_W-1:0];
        end else if (dp.SelAcc[0]) begin
            acc_d = reg_q;
        end
    end

    assign pc_target = dp.SelPC ? ADDR_W'(imm) : ADDR_W'(reg_q);

    always_ff @(posedge CLK) begin
        if (!CLB) begin
            ir_q  <= '0;
            pc_q  <= '0;
            acc_q <= '0;
            reg_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            if (dp.LoadIR) begin
                ir_q <= dp.InstrData;
            end
            if (!halted) begin
                if (dp.LoadPC) begin
                    pc_q <= pc_target;
                end else if (dp.IncPC) begin
                    pc_q <= pc_q + ADDR_W'(1);
                end
            end
            if (dp.LoadAcc) begin
                acc_q <= acc_d;
                z_q   <= (acc_d == '0);
                if (dp.SelAcc[1]) begin
                    c_q <= alu_res[DATA_W];
                end
            end
            if (dp.LoadReg) begin
                reg_q <= acc_q;
            end
        end
    end

`ifdef DATAPATH_OVF_FLAG_EN
    logic v_q, alu_v;

    always_comb begin
        alu_v = 1'b0;
        if (dp.SelALU == 4'b0001) begin
            alu_v = (acc_q[Msb] == reg_q[Msb]) && (alu_res[Msb] != acc_q[Msb]);
        end else if (dp.SelALU == 4'b0010) begin
            alu_v = (acc_q[Msb] != reg_q[Msb]) && (alu_res[Msb] != acc_q[Msb]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLB) begin
            v_q <= 1'b0;
        end else if (dp.LoadAcc && dp.SelAcc[1]) begin
            v_q <= alu_v;
        end
    end

    assign dp.V = v_q;
`endif

    assign dp.PCAddr = pc_q;
    assign dp.Opcode = ir_q[3+DATA_W:DATA_W];
    assign dp.Z      = z_q;
    assign dp.C      = c_q;
    assign dp.AccOut = acc_q;
    assign dp.Halted = halted;
endmodule
